// File: rtl/systolic_result_drain.sv
// Output-side controller for the NxN systolic array: runs the array for a fixed window,
// snapshots the accumulators, requantizes them to int8 and streams one row per beat.
module systolic_result_drain #(
    parameter int N              = 8,
    parameter int ACC_W          = 32,
    parameter int OUT_W          = 8,
    parameter int COMPUTE_CYCLES = 3*N-2
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_start,
    input  logic [4:0]             i_shift,
    output logic                   o_doProcess,
    input  logic [N*N*ACC_W-1:0]   i_c,
    output logic [N*OUT_W-1:0]     o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(N)-1:0]   o_rowIdx,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int ROW_W = N*ACC_W;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(COMPUTE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES-1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(N-1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -((ACC_W+1)'(2**(OUT_W-1)));

    typedef enum logic [1:0] {IDLE, COMPUTE, CAPTURE, STREAM} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [4:0]           shift;
    logic [N*N*ACC_W-1:0] snapshot;
    logic                 accept;
    logic [IDX_W-1:0]     next_row;
    logic [ROW_W-1:0]     src_row;
    logic [N*OUT_W-1:0]   req_row;

    // Rounded arithmetic right shift at ACC_W+1 bits, then saturation to the output range.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] x, input logic [4:0] s);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] y;
        ext = $signed({x[ACC_W-1], x});
        rnd = '0;
        if (s != 5'd0)
            rnd = (ACC_W+1)'(1) << (s - 5'd1);
        y = (ext + rnd) >>> s;
        if (y > SAT_MAX)
            y = SAT_MAX;
        else if (y < SAT_MIN)
            y = SAT_MIN;
        return y[OUT_W-1:0];
    endfunction

    assign accept      = o_valid && i_ready;
    assign next_row    = o_rowIdx + IDX_W'(1);
    assign o_doProcess = (state == COMPUTE);
    assign o_busy      = (state != IDLE);

    // Row 0 is requantized straight from i_c while it is being snapshotted, so the
    // registered output is already valid in the first STREAM cycle.
    always_comb begin
        src_row = snapshot[int'(next_row)*ROW_W +: ROW_W];
        if (state == CAPTURE)
            src_row = i_c[ROW_W-1:0];
    end

    always_comb begin
        req_row = '0;
        for (int c = 0; c < N; c++)
            req_row[c*OUT_W +: OUT_W] = requant(src_row[c*ACC_W +: ACC_W], shift);
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = COMPUTE;
            COMPUTE: if (cycle_cnt == CNT_LAST) state_next = CAPTURE;
            CAPTURE: state_next = STREAM;
            STREAM:  if (accept && o_rowIdx == ROW_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            cycle_cnt <= '0;
            shift     <= '0;
            snapshot  <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_rowIdx  <= '0;
            o_last    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        shift     <= i_shift;
                        cycle_cnt <= '0;
                    end
                end
                COMPUTE: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
                CAPTURE: begin
                    snapshot <= i_c;
                    o_data   <= req_row;
                    o_rowIdx <= '0;
                    o_valid  <= 1'b1;
                    o_last   <= (N == 1);
                end
                STREAM: begin
                    if (accept) begin
                        if (o_rowIdx == ROW_LAST) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            o_rowIdx <= next_row;
                            o_data   <= req_row;
                            o_last   <= (next_row == ROW_LAST);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: expected rows are queued at start and
// compared as the DUT streams them, under directed and random backpressure.
module tb_systolic_result_drain;

    localparam int N     = 8;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int CC    = 3*N-2;

    logic                 i_clk = 1'b0;
    logic                 i_arst = 1'b0;
    logic                 i_start = 1'b0;
    logic [4:0]           i_shift = '0;
    logic                 o_doProcess;
    logic [N*N*ACC_W-1:0] i_c = '0;
    logic [N*OUT_W-1:0]   o_data;
    logic                 o_valid;
    logic                 i_ready = 1'b0;
    logic [2:0]           o_rowIdx;
    logic                 o_last;
    logic                 o_busy;
    logic                 o_done;

    typedef struct {
        logic [N*OUT_W-1:0] data;
        logic [2:0]         idx;
        logic               last;
    } exp_row_t;

    exp_row_t           sb[$];
    int                 passes = 0;
    int                 fails = 0;
    int                 total = 0;
    logic [N*OUT_W-1:0] first_row = '0;

    systolic_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .COMPUTE_CYCLES(CC)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_shift(i_shift),
        .o_doProcess(o_doProcess), .i_c(i_c), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_rowIdx(o_rowIdx), .o_last(o_last), .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_elem(input int r, input int c, input logic [31:0] v);
        i_c[(r*N+c)*ACC_W +: ACC_W] = v;
    endtask

    function automatic logic [7:0] model_q(input longint x, input int s);
        longint y;
        if (s == 0)
            y = x;
        else
            y = (x + (longint'(1) << (s-1))) >>> s;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    function automatic void push_expected(input logic [4:0] s);
        exp_row_t e;
        for (int r = 0; r < N; r++) begin
            e.data = '0;
            for (int c = 0; c < N; c++)
                e.data[c*OUT_W +: OUT_W] =
                    model_q(longint'($signed(i_c[(r*N+c)*ACC_W +: ACC_W])), int'(s));
            e.idx  = 3'(r);
            e.last = (r == N-1);
            sb.push_back(e);
        end
    endfunction

    // Runs one transfer from start pulse to o_done; returns inside the o_done cycle.
    task automatic run_check(input logic [4:0] shift, input int ready_pct,
                             input bit poke, input bit scramble);
        int               cyc;
        int               dp_cnt;
        int               first_valid;
        int               done_cyc;
        bit               stall;
        bit               acc_last;
        logic [63:0]      held;
        exp_row_t         e;
        cyc = 0; dp_cnt = 0; first_valid = 0; done_cyc = 0;
        stall = 0; acc_last = 0; held = '0;
        push_expected(shift);
        i_shift = shift;
        i_start = 1'b1;
        i_ready = ($urandom_range(1, 100) <= ready_pct);
        tick();
        cyc = 1;
        i_start = 1'b0;
        i_shift = ~shift;
        while (done_cyc == 0 && cyc < 200) begin
            if (o_doProcess) dp_cnt++;
            check("do_process", o_doProcess, (cyc <= CC));
            check("busy", o_busy, !acc_last);
            check("done", o_done, acc_last);
            if (o_done) done_cyc = cyc;
            if (stall) check("stall_hold", o_data, held);
            if (sb.size() == 0) begin
                check("no_extra_row", o_valid, 0);
            end else if (o_valid) begin
                if (first_valid == 0) begin
                    first_valid = cyc;
                    first_row   = o_data;
                end
                e = sb[0];
                check("row_data", o_data, e.data);
                check("row_idx", o_rowIdx, e.idx);
                check("row_last", o_last, e.last);
            end else if (stall) begin
                check("valid_held", o_valid, 1);
            end
            if (done_cyc == 0) begin
                i_ready  = ($urandom_range(1, 100) <= ready_pct);
                stall    = o_valid && !i_ready;
                held     = o_data;
                acc_last = 0;
                if (o_valid && i_ready && sb.size() != 0) begin
                    acc_last = sb[0].last;
                    void'(sb.pop_front());
                end
                i_start = poke && (cyc == 5 || (first_valid != 0 && cyc == first_valid + 1));
                if (scramble && first_valid != 0) i_c = ~i_c;
                tick();
                cyc++;
            end
        end
        i_start = 1'b0;
        check("done_seen", (done_cyc != 0), 1);
        check("do_process_len", dp_cnt, CC);
        check("sb_empty", sb.size(), 0);
        if (ready_pct >= 100) begin
            check("first_valid_lat", first_valid, CC+2);
            check("done_lat", done_cyc, CC+N+2);
        end
        sb.delete();
    endtask

    initial begin
        // Reset state and idle
        repeat (3) tick();
        check("rst_do_process", o_doProcess, 0);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_data", o_data, 0);
        check("rst_row_idx", o_rowIdx, 0);
        i_arst = 1'b1;
        repeat (2) tick();
        check("idle_busy", o_busy, 0);
        check("idle_valid", o_valid, 0);

        // Ramp matrix, no shift, sink always ready
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'(r*8 + c));
        run_check(5'd0, 100, 0, 0);
        check("ramp_row0", first_row, 64'h0706050403020100);

        // Rounding and saturation, started on the previous o_done cycle
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'($urandom_range(0, 400)) - 32'd200);
        set_elem(0, 0, 32'd23);
        set_elem(0, 1, 32'd24);
        set_elem(0, 2, -32'd24);
        set_elem(0, 3, -32'd25);
        set_elem(0, 4, 32'd100000);
        set_elem(0, 5, -32'd100000);
        run_check(5'd4, 100, 0, 0);
        check("q_23", first_row[7:0], 8'h01);
        check("q_24", first_row[15:8], 8'h02);
        check("q_m24", first_row[23:16], 8'hFF);
        check("q_m25", first_row[31:24], 8'hFE);
        check("q_sat_hi", first_row[39:32], 8'h7F);
        check("q_sat_lo", first_row[47:40], 8'h80);

        // Random backpressure
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'($urandom_range(0, 4000)) - 32'd2000);
        run_check(5'd3, 50, 0, 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'($urandom));
        run_check(5'd0, 30, 0, 0);

        // Start pulses during COMPUTE and STREAM with another shift are ignored
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'($urandom_range(0, 1000)) - 32'd500);
        run_check(5'd2, 100, 1, 0);
        run_check(5'd5, 100, 0, 0);

        // Input matrix changing after CAPTURE has no effect
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'($urandom_range(0, 600)) - 32'd300);
        run_check(5'd1, 70, 0, 1);

        // Asynchronous reset in the middle of STREAM
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                set_elem(r, c, 32'(r*8 + c + 1));
        i_shift = 5'd0;
        i_start = 1'b1;
        i_ready = 1'b0;
        tick();
        i_start = 1'b0;
        begin
            int k;
            k = 0;
            while (!o_valid && k < 60) begin
                tick();
                k++;
            end
        end
        check("mid_valid", o_valid, 1);
        i_ready = 1'b1;
        repeat (2) tick();
        i_ready = 1'b0;
        tick();
        check("mid_row_idx", o_rowIdx, 2);
        #3 i_arst = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_busy", o_busy, 0);
        check("arst_do_process", o_doProcess, 0);
        check("arst_last", o_last, 0);
        check("arst_done", o_done, 0);
        check("arst_data", o_data, 0);
        check("arst_row_idx", o_rowIdx, 0);
        tick();
        i_arst = 1'b1;
        i_ready = 1'b1;
        repeat (30) begin
            tick();
            check("no_done_after_reset", o_done, 0);
            check("idle_after_reset", o_busy, 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
